// File: rtl/bus_pkg.sv
// Shared definitions for the serial memory slave: default widths and the slave state encoding.
package bus_pkg;

  localparam int ADDR_LEN_DEFAULT  = 12;
  localparam int DATA_LEN_DEFAULT  = 8;
  localparam int BURST_LEN_DEFAULT = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_WDATA,
    S_WCOMMIT,
    S_RFETCH,
    S_RDATA,
    S_DONE
  } slave_state_e;

endpackage

// File: rtl/serial_mem_slave_if.sv
// Serial master/slave bus: address, burst and data are all one bit wide, shifted LSB first.
interface serial_mem_slave_if;

  logic [5:0] slave_delay;
  logic       master_valid;
  logic       master_ready;
  logic       write_en;
  logic       read_en;
  logic       rx_address;
  logic       rx_burst;
  logic       rx_data;
  logic       slave_ready;
  logic       slave_valid;
  logic       tx_data;
  logic       split_en;

  modport slave (
    input  slave_delay, master_valid, master_ready, write_en, read_en,
           rx_address, rx_burst, rx_data,
    output slave_ready, slave_valid, tx_data, split_en
  );

  modport master (
    output slave_delay, master_valid, master_ready, write_en, read_en,
           rx_address, rx_burst, rx_data,
    input  slave_ready, slave_valid, tx_data, split_en
  );

endinterface

// File: rtl/slave_bram.sv
// Single-port backing store: synchronous write, registered read with one cycle of latency.
module slave_bram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array and its read register carry no reset, so contents survive a bus reset
  // and the store can map onto block RAM.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/serial_mem_slave.sv
// Non-split serial memory slave: shifts in address/burst, waits slave_delay cycles,
// then streams DATA_LEN-bit beats in (write) or out (read) of a single-port store.
module serial_mem_slave
  import bus_pkg::*;
#(
  parameter int ADDR_LEN  = ADDR_LEN_DEFAULT,
  parameter int DATA_LEN  = DATA_LEN_DEFAULT,
  parameter int BURST_LEN = BURST_LEN_DEFAULT,
  parameter int MEM_DEPTH = 2 ** ADDR_LEN
) (
  input logic               clk,
  input logic               reset,
  serial_mem_slave_if.slave bus
);

  localparam int ACNT_W = $clog2(ADDR_LEN);
  localparam int DCNT_W = $clog2(DATA_LEN);

  slave_state_e         state_q;
  logic                 op_write_q;
  logic [ADDR_LEN-1:0]  addr_q;
  logic [BURST_LEN-1:0] burst_q;
  logic [ACNT_W-1:0]    addr_cnt_q;
  logic [DCNT_W-1:0]    bit_cnt_q;
  logic [BURST_LEN-1:0] beat_idx_q;
  logic [5:0]           wait_cnt_q;
  logic [DATA_LEN-1:0]  wdata_q;
  logic                 slave_ready_q;
  logic                 slave_valid_q;

  logic [BURST_LEN-1:0] last_beat_idx;
  logic                 is_last_beat;
  logic                 last_addr_bit;
  logic                 last_data_bit;
  logic [ADDR_LEN-1:0]  mem_addr;
  logic                 mem_en;
  logic                 mem_we;
  logic [DATA_LEN-1:0]  rd_word;

  // A captured burst of zero still moves one beat.
  assign last_beat_idx = (burst_q == '0) ? '0 : burst_q - BURST_LEN'(1);
  assign is_last_beat  = (beat_idx_q == last_beat_idx);
  assign last_addr_bit = (addr_cnt_q == ACNT_W'(ADDR_LEN - 1));
  assign last_data_bit = (bit_cnt_q == DCNT_W'(DATA_LEN - 1));
  assign mem_addr      = addr_q + ADDR_LEN'(beat_idx_q);
  assign mem_en        = (state_q == S_WCOMMIT) || (state_q == S_RFETCH);
  assign mem_we        = (state_q == S_WCOMMIT);

  slave_bram #(
    .ADDR_W (ADDR_LEN),
    .DATA_W (DATA_LEN),
    .DEPTH  (MEM_DEPTH)
  ) u_bram (
    .clk     (clk),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (wdata_q),
    .rdata_o (rd_word)
  );

  // NOTE: every register in this process uses <= so all transitions see the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_write_q    <= 1'b0;
      addr_q        <= '0;
      burst_q       <= '0;
      addr_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      beat_idx_q    <= '0;
      wait_cnt_q    <= '0;
      wdata_q       <= '0;
      slave_ready_q <= 1'b1;
      slave_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.master_valid && (bus.write_en ^ bus.read_en)) begin
            op_write_q    <= bus.write_en;
            addr_q        <= {bus.rx_address, addr_q[ADDR_LEN-1:1]};
            burst_q       <= {bus.rx_burst, burst_q[BURST_LEN-1:1]};
            addr_cnt_q    <= ACNT_W'(1);
            bit_cnt_q     <= '0;
            beat_idx_q    <= '0;
            state_q       <= S_ADDR;
            slave_ready_q <= 1'b0;
          end
        end

        S_ADDR: begin
          if (!bus.master_valid) begin
            state_q       <= S_IDLE;
            slave_ready_q <= 1'b1;
          end else begin
            addr_q  <= {bus.rx_address, addr_q[ADDR_LEN-1:1]};
            burst_q <= {bus.rx_burst, burst_q[BURST_LEN-1:1]};
            if (last_addr_bit) begin
              addr_cnt_q <= '0;
              if (bus.slave_delay != '0) begin
                wait_cnt_q <= bus.slave_delay;
                state_q    <= S_WAIT;
              end else if (op_write_q) begin
                state_q       <= S_WDATA;
                slave_ready_q <= 1'b1;
              end else begin
                state_q <= S_RFETCH;
              end
            end else begin
              addr_cnt_q <= addr_cnt_q + ACNT_W'(1);
            end
          end
        end

        S_WAIT: begin
          if (wait_cnt_q == 6'd1) begin
            wait_cnt_q <= '0;
            if (op_write_q) begin
              state_q       <= S_WDATA;
              slave_ready_q <= 1'b1;
            end else begin
              state_q <= S_RFETCH;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q - 6'd1;
          end
        end

        // master_valid low here is a stall, not an abort.
        S_WDATA: begin
          if (bus.master_valid) begin
            wdata_q <= {bus.rx_data, wdata_q[DATA_LEN-1:1]};
            if (last_data_bit) begin
              bit_cnt_q     <= '0;
              state_q       <= S_WCOMMIT;
              slave_ready_q <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + DCNT_W'(1);
            end
          end
        end

        S_WCOMMIT: begin
          if (is_last_beat) begin
            state_q <= S_DONE;
          end else begin
            beat_idx_q    <= beat_idx_q + BURST_LEN'(1);
            state_q       <= S_WDATA;
            slave_ready_q <= 1'b1;
          end
        end

        S_RFETCH: begin
          state_q       <= S_RDATA;
          slave_valid_q <= 1'b1;
        end

        S_RDATA: begin
          if (bus.master_ready) begin
            if (last_data_bit) begin
              bit_cnt_q     <= '0;
              slave_valid_q <= 1'b0;
              if (is_last_beat) begin
                state_q <= S_DONE;
              end else begin
                beat_idx_q <= beat_idx_q + BURST_LEN'(1);
                state_q    <= S_RFETCH;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + DCNT_W'(1);
            end
          end
        end

        S_DONE: begin
          state_q       <= S_IDLE;
          slave_ready_q <= 1'b1;
        end

        default: begin
          state_q       <= S_IDLE;
          slave_ready_q <= 1'b1;
          slave_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.slave_ready = slave_ready_q;
  assign bus.slave_valid = slave_valid_q;
  assign bus.tx_data     = slave_valid_q & rd_word[bit_cnt_q];
  assign bus.split_en    = 1'b0;

endmodule

// File: tb/tb_serial_mem_slave.sv
// Directed bench for serial_mem_slave: write/read-back, burst wrap, delay with backpressure,
// abort, illegal request and reset in the middle of a burst.
module tb_serial_mem_slave;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  serial_mem_slave_if bus_if ();

  serial_mem_slave dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start cycle plus ADDR_LEN-1 address cycles; returns at the first cycle after the address.
  task automatic drive_addr(input logic wr, input logic [11:0] a, input logic [11:0] b,
                            input logic [5:0] d, input int abort_bit);
    bus_if.slave_delay = d;
    for (int i = 0; i < 12; i++) begin
      if (i == abort_bit) begin
        bus_if.master_valid = 1'b0;
        bus_if.write_en     = 1'b0;
        bus_if.read_en      = 1'b0;
        tick();
        return;
      end
      bus_if.master_valid = 1'b1;
      bus_if.write_en     = wr;
      bus_if.read_en      = ~wr;
      bus_if.rx_address   = a[i];
      bus_if.rx_burst     = b[i];
      tick();
    end
    bus_if.write_en     = 1'b0;
    bus_if.read_en      = 1'b0;
    bus_if.rx_address   = 1'b0;
    bus_if.rx_burst     = 1'b0;
    bus_if.master_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [11:0] a, input logic [11:0] b, input logic [5:0] d,
                             input logic [31:0] words, input int stop_bit,
                             output int ready_cycle);
    int cyc;
    int nbeats;
    int gbit;
    int n;
    nbeats      = (b == 12'd0) ? 1 : int'(b);
    ready_cycle = -1;
    drive_addr(1'b1, a, b, d, -1);
    cyc  = 12;
    gbit = 0;
    for (int beat = 0; beat < nbeats; beat++) begin
      for (int bt = 0; bt < 8; bt++) begin
        if (gbit == stop_bit) begin
          bus_if.master_valid = 1'b0;
          return;
        end
        bus_if.master_valid = 1'b1;
        bus_if.rx_data      = words[gbit];
        n = 0;
        while (!bus_if.slave_ready && n < 80) begin
          tick();
          cyc++;
          n++;
        end
        if (!bus_if.slave_ready) begin
          check("wr_ready_timeout", 32'(bus_if.slave_ready), 32'd1);
          bus_if.master_valid = 1'b0;
          return;
        end
        if (ready_cycle < 0) ready_cycle = cyc;
        tick();
        cyc++;
        gbit++;
      end
    end
    bus_if.master_valid = 1'b0;
    bus_if.rx_data      = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic read_burst(input logic [11:0] a, input logic [11:0] b, input logic [5:0] d,
                            input int stall_at, input int stall_len, input logic hold_exp,
                            output logic [31:0] words, output int first_valid);
    int   cyc;
    int   total;
    int   nbits;
    int   stalls;
    logic bad_idle_tx;
    total       = 8 * ((b == 12'd0) ? 1 : int'(b));
    words       = '0;
    first_valid = -1;
    nbits       = 0;
    stalls      = 0;
    bad_idle_tx = 1'b0;
    drive_addr(1'b0, a, b, d, -1);
    cyc = 12;
    while (nbits < total && cyc < 400) begin
      bus_if.master_ready = 1'b1;
      if (bus_if.slave_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (nbits == stall_at && stalls < stall_len) begin
          bus_if.master_ready = 1'b0;
          stalls++;
          check("rd_hold_bit", 32'(bus_if.tx_data), 32'(hold_exp));
        end else begin
          words[nbits] = bus_if.tx_data;
          nbits++;
        end
      end else if (bus_if.tx_data !== 1'b0) begin
        bad_idle_tx = 1'b1;
      end
      tick();
      cyc++;
    end
    bus_if.master_ready = 1'b1;
    check("rd_bits_received", 32'(nbits), 32'(total));
    check("rd_tx_zero_when_invalid", 32'(bad_idle_tx), 32'd0);
    tick();
    tick();
  endtask

  logic [31:0] rd_words;
  int          first_valid;
  int          ready_cycle;

  initial begin
    checks                = 0;
    failures              = 0;
    reset                 = 1'b1;
    bus_if.slave_delay    = 6'd0;
    bus_if.master_valid   = 1'b0;
    bus_if.master_ready   = 1'b1;
    bus_if.write_en       = 1'b0;
    bus_if.read_en        = 1'b0;
    bus_if.rx_address     = 1'b0;
    bus_if.rx_burst       = 1'b0;
    bus_if.rx_data        = 1'b0;
    tick();
    tick();
    check("rst_slave_ready", 32'(bus_if.slave_ready), 32'd1);
    check("rst_slave_valid", 32'(bus_if.slave_valid), 32'd0);
    check("rst_tx_data", 32'(bus_if.tx_data), 32'd0);
    check("rst_split_en", 32'(bus_if.split_en), 32'd0);
    reset = 1'b0;
    tick();

    // Single write of 0xA5 to 0x010, then read it back.
    write_burst(12'h010, 12'd1, 6'd0, 32'h0000_00A5, -1, ready_cycle);
    check("wr_first_ready_cycle", 32'(ready_cycle), 32'd12);
    read_burst(12'h010, 12'd1, 6'd0, -1, 0, 1'b0, rd_words, first_valid);
    check("rd_a5_word", rd_words[7:0], 32'h0000_00A5);
    check("rd_a5_first_valid", 32'(first_valid), 32'd13);

    // Burst of three wrapping from 0xFFF to 0x001.
    write_burst(12'hFFF, 12'd3, 6'd0, 32'h0033_2211, -1, ready_cycle);
    read_burst(12'hFFF, 12'd1, 6'd0, -1, 0, 1'b0, rd_words, first_valid);
    check("wrap_rd_fff", rd_words[7:0], 32'h11);
    read_burst(12'h000, 12'd1, 6'd0, -1, 0, 1'b0, rd_words, first_valid);
    check("wrap_rd_000", rd_words[7:0], 32'h22);
    read_burst(12'h001, 12'd1, 6'd0, -1, 0, 1'b0, rd_words, first_valid);
    check("wrap_rd_001", rd_words[7:0], 32'h33);
    read_burst(12'hFFF, 12'd3, 6'd0, -1, 0, 1'b0, rd_words, first_valid);
    check("wrap_burst_read", rd_words, 32'h0033_2211);

    // Delay of 5 with master_ready low for 3 cycles while bit 2 (a 1) is presented.
    read_burst(12'h010, 12'd1, 6'd5, 2, 3, 1'b1, rd_words, first_valid);
    check("delay_first_valid", 32'(first_valid), 32'd18);
    check("delay_stall_word", rd_words[7:0], 32'h0000_00A5);
    write_burst(12'h020, 12'd1, 6'd3, 32'h0000_005A, -1, ready_cycle);
    check("delay_wr_first_ready", 32'(ready_cycle), 32'd15);
    read_burst(12'h020, 12'd1, 6'd0, -1, 0, 1'b0, rd_words, first_valid);
    check("delay_wr_word", rd_words[7:0], 32'h0000_005A);

    // Burst count of zero moves exactly one beat.
    write_burst(12'h101, 12'd1, 6'd0, 32'h0000_0077, -1, ready_cycle);
    write_burst(12'h100, 12'd0, 6'd0, 32'h0000_003C, -1, ready_cycle);
    read_burst(12'h100, 12'd1, 6'd0, -1, 0, 1'b0, rd_words, first_valid);
    check("burst0_rd_100", rd_words[7:0], 32'h3C);
    read_burst(12'h101, 12'd1, 6'd0, -1, 0, 1'b0, rd_words, first_valid);
    check("burst0_rd_101", rd_words[7:0], 32'h77);

    // Abort at address bit 6, then an illegal write+read request.
    drive_addr(1'b1, 12'h010, 12'd1, 6'd0, 6);
    check("abort_idle_ready", 32'(bus_if.slave_ready), 32'd1);
    bus_if.master_valid = 1'b1;
    bus_if.write_en     = 1'b1;
    bus_if.read_en      = 1'b1;
    bus_if.rx_address   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("illegal_stays_idle", 32'(bus_if.slave_ready), 32'd1);
    end
    bus_if.master_valid = 1'b0;
    bus_if.write_en     = 1'b0;
    bus_if.read_en      = 1'b0;
    bus_if.rx_address   = 1'b0;
    tick();
    read_burst(12'h010, 12'd1, 6'd0, -1, 0, 1'b0, rd_words, first_valid);
    check("abort_mem_unchanged", rd_words[7:0], 32'h0000_00A5);
    check("abort_rd_first_valid", 32'(first_valid), 32'd13);

    // Reset while beat 2 of a 4-beat write is being shifted in.
    write_burst(12'h200, 12'd4, 6'd0, 32'hEEEE_EEEE, -1, ready_cycle);
    write_burst(12'h200, 12'd4, 6'd0, 32'h0403_0201, 19, ready_cycle);
    reset = 1'b1;
    tick();
    check("midrst_slave_ready", 32'(bus_if.slave_ready), 32'd1);
    check("midrst_slave_valid", 32'(bus_if.slave_valid), 32'd0);
    check("midrst_tx_data", 32'(bus_if.tx_data), 32'd0);
    reset = 1'b0;
    tick();
    read_burst(12'h200, 12'd4, 6'd0, -1, 0, 1'b0, rd_words, first_valid);
    check("midrst_readback", rd_words, 32'hEEEE_0201);
    check("split_en_tied_low", 32'(bus_if.split_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_mem_slave.md
SERIAL_MEM_SLAVE -- requirements
Module: serial_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 12, which is the serial address width in bits.
REQ-002 SHALL have parameter DATA_LEN, default 8, which is the data word width in bits.
REQ-003 SHALL have parameter BURST_LEN, default 12, which is the serial burst-count width and SHALL equal ADDR_LEN.
REQ-004 SHALL have parameter MEM_DEPTH, default 4096, which is the number of words in the backing store (2**ADDR_LEN).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port slave_delay, input, 6 bits: wait cycles inserted between the address phase and the data phase.
REQ-008 SHALL have port master_valid, input, 1 bit: the master is driving valid serial bits.
REQ-009 SHALL have port master_ready, input, 1 bit: the master accepts the current tx_data bit.
REQ-010 SHALL have port write_en, input, 1 bit: write request, sampled at start.
REQ-011 SHALL have port read_en, input, 1 bit: read request, sampled at start.
REQ-012 SHALL have port rx_address, input, 1 bit: serial address, LSB first.
REQ-013 SHALL have port rx_burst, input, 1 bit: serial beat count, LSB first, shifted in parallel with rx_address.
REQ-014 SHALL have port rx_data, input, 1 bit: serial write data, LSB first.
REQ-015 SHALL have port slave_ready, output, 1 bit: the slave accepts the start command or write bits.
REQ-016 SHALL have port slave_valid, output, 1 bit: tx_data carries a valid read bit.
REQ-017 SHALL have port tx_data, output, 1 bit: serial read data, LSB first.
REQ-018 SHALL have port split_en, output, 1 bit: split request; tied to 0 because this is a non-split slave.

Function
REQ-019 SHALL implement the states IDLE, ADDR, WAIT, WDATA, WCOMMIT, RFETCH, RDATA and DONE.
REQ-020 IDLE SHALL behave as follows.
- slave_ready=1.
- The start cycle is master_valid=1 with exactly one of write_en/read_en set.
- On the start cycle the slave latches the operation, captures address/burst bit 0, and moves to ADDR.
- write_en=read_en=1 is ignored: the slave stays in IDLE and memory is untouched.
REQ-021 ADDR SHALL capture bits 1..ADDR_LEN-1, one per cycle, while master_valid=1.
- slave_ready=0.
- master_valid=0 in ADDR aborts the transaction: go to IDLE, no memory access.
REQ-022 After the last address bit the slave SHALL do one of the following.
- If slave_delay>0, enter WAIT for exactly slave_delay cycles.
- Otherwise go directly to WDATA (write) or RFETCH (read).
REQ-023 The beat count SHALL be the captured burst value, with 0 treated as 1.
- Beat address = start address + beat index, modulo 2**ADDR_LEN (wraps 0xFFF->0x000).
REQ-024 WDATA SHALL have slave_ready=1.
- Each cycle with master_valid=1 shifts in one rx_data bit.
- master_valid=0 stalls with no shift; it is not an abort.
REQ-025 After DATA_LEN bits the slave SHALL enter WCOMMIT for 1 cycle.
- slave_ready=0.
- mem[beat addr] is written.
- Then go to WDATA for the next beat, or to DONE after the last beat.
REQ-026 RFETCH SHALL last 1 cycle and issue the memory read (1-cycle latency), then go to RDATA.
REQ-027 RDATA SHALL have slave_valid=1 and tx_data = current bit of the fetched word, LSB first.
- The bit index advances only on cycles with master_ready=1.
- After DATA_LEN accepted bits, go to RFETCH for the next beat, or to DONE.
REQ-028 DONE SHALL last 1 cycle, with slave_ready=0 and slave_valid=0, then go to IDLE.
REQ-029 The data phase SHALL begin at a fixed cycle after the start cycle (start = cycle 0).
- With slave_delay=0: first WDATA cycle, or RFETCH, is cycle ADDR_LEN.
- With slave_delay=0: first slave_valid cycle is cycle ADDR_LEN+1.
- Each slave_delay cycle adds one cycle to both.
REQ-030 tx_data SHALL be 0 whenever slave_valid=0; slave_valid SHALL be 0 outside RDATA.
REQ-031 The block SHALL ignore all inputs except reset while it is not in IDLE, ADDR or the data states.

Reset
REQ-032 reset=1 at a clock edge SHALL produce all of the following, from any state including mid-burst.
- State becomes IDLE.
- Counters, shift registers and the latched operation are cleared.
- slave_ready=1, slave_valid=0, tx_data=0, split_en=0.
REQ-033 Reset SHALL NOT clear memory contents, and any beat not yet committed SHALL be discarded.

Structure
REQ-034 The following SHALL live in the shared package bus_pkg.
- ADDR_LEN, DATA_LEN and BURST_LEN defaults.
- The slave state enum.
REQ-035 The memory SHALL be a sub-module slave_bram with these properties.
- Single port.
- MEM_DEPTH x DATA_LEN.
- Synchronous write, registered read (1-cycle latency).

Verification
REQ-036 Single write then read-back.
- Stimulus: write 0xA5 to address 0x010, burst 1, delay 0; then read 0x010.
- Required response: tx_data bits 1,0,1,0,0,1,0,1.
- Required response: slave_valid first high on cycle 13 after the read start.
REQ-037 Burst wrap.
- Stimulus: write burst 3 at 0xFFF with data 0x11, 0x22, 0x33.
- Required response: reads of 0xFFF, 0x000 and 0x001 return 0x11, 0x22 and 0x33.
REQ-038 Delay and backpressure.
- Stimulus: read with slave_delay=5 and master_ready low for 3 cycles mid-word.
- Required response: slave_valid first high on cycle 18.
- Required response: tx_data held for the 3 stall cycles; the word is still correct.
REQ-039 Abort and illegal request.
- Stimulus: master_valid dropped at address bit 6.
- Required response: return to IDLE, memory unchanged.
- Stimulus: write_en=read_en=1.
- Required response: stays in IDLE with slave_ready=1.
REQ-040 Reset mid-burst.
- Stimulus: reset asserted during beat 2 of a 4-beat write.
- Required response: IDLE next cycle; beats 0 and 1 are written; beats 2 and 3 are unwritten.
